// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage in front of the pipeline ALU.
// Decodes an RV32I instruction and its register operands into an ALU request
// (op code, operand A, operand B, rd). The request sits in an output register
// with a one-entry skid buffer behind a valid/ready handshake.
// Optional build macro: ALU_BYPASS_EN forwards res_alu_i into the operands
// when the entry handed to EX on the previous cycle writes a source register.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [OP_W-1:0] op_alu_o,
    output logic [XLEN-1:0] opr_a_alu_o,
    output logic [XLEN-1:0] opr_b_alu_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o,
    input  logic [XLEN-1:0] res_alu_i
);

    // ALU op-code encodings shared with the ALU
    localparam logic [OP_W-1:0] ADD_OP  = 6'd0;
    localparam logic [OP_W-1:0] SUB_OP  = 6'd1;
    localparam logic [OP_W-1:0] SHL_OP  = 6'd2;
    localparam logic [OP_W-1:0] LSR_OP  = 6'd3;
    localparam logic [OP_W-1:0] ASR_OP  = 6'd4;
    localparam logic [OP_W-1:0] OR_OP   = 6'd5;
    localparam logic [OP_W-1:0] AND_OP  = 6'd6;
    localparam logic [OP_W-1:0] XOR_OP  = 6'd7;
    localparam logic [OP_W-1:0] SLT_OP  = 6'd9;
    localparam logic [OP_W-1:0] SLTU_OP = 6'd10;

    // RV32I major opcodes handled here
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_BOTH  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    entry_t          r_out;
    entry_t          r_skid;
    entry_t          w_dec;
    logic            w_accept;
    logic            w_hs;
    logic            w_load_out_in;
    logic            w_load_out_skid;
    logic            w_load_skid;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic [OP_W-1:0] w_base_op;

    assign w_accept    = in_valid_i & r_in_ready;
    assign out_valid_o = (r_state != S_EMPTY);
    assign w_hs        = out_valid_o & out_ready_i;

    assign in_ready_o  = r_in_ready;
    assign op_alu_o    = r_out.op;
    assign opr_a_alu_o = r_out.a;
    assign opr_b_alu_o = r_out.b;
    assign rd_o        = r_out.rd;
    assign illegal_o   = r_out.ill;

`ifdef ALU_BYPASS_EN
    logic       r_fwd_valid;
    logic [4:0] r_fwd_rd;

    // remember rd of the entry handed to EX at this edge (x0 never forwards)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_rd    <= '0;
        end else begin
            r_fwd_valid <= w_hs && (r_out.rd != 5'd0);
            r_fwd_rd    <= r_out.rd;
        end
    end

    // bypass resolves on the input side, so a SKID capture keeps its operands
    assign w_rs1_val = (r_fwd_valid && (instr_i[19:15] == r_fwd_rd)) ? res_alu_i : rs1_data_i;
    assign w_rs2_val = (r_fwd_valid && (instr_i[24:20] == r_fwd_rd)) ? res_alu_i : rs2_data_i;
`else
    logic w_unused_byp;

    assign w_rs1_val    = rs1_data_i;
    assign w_rs2_val    = rs2_data_i;
    assign w_unused_byp = ^{res_alu_i, instr_i[19:15]};
`endif

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_u  = {instr_i[31:12], 12'b0};
    assign w_shamt  = {27'b0, instr_i[24:20]};

    // funct3 to ALU op for the non-SUB/SRA forms shared by OP and OP-IMM
    always_comb begin
        w_base_op = ADD_OP;
        case (w_f3)
            3'b000:  w_base_op = ADD_OP;
            3'b001:  w_base_op = SHL_OP;
            3'b010:  w_base_op = SLT_OP;
            3'b011:  w_base_op = SLTU_OP;
            3'b100:  w_base_op = XOR_OP;
            3'b101:  w_base_op = LSR_OP;
            3'b110:  w_base_op = OR_OP;
            default: w_base_op = AND_OP;
        endcase
    end

    // instruction decode into an ALU request; illegal forms collapse to ADD 0,0
    always_comb begin
        w_dec.op  = ADD_OP;
        w_dec.a   = '0;
        w_dec.b   = '0;
        w_dec.rd  = instr_i[11:7];
        w_dec.ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_dec.a = w_rs1_val;
                w_dec.b = w_rs2_val;
                if (w_f7 == 7'b0000000)
                    w_dec.op = w_base_op;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
                    w_dec.op = SUB_OP;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
                    w_dec.op = ASR_OP;
                else
                    w_dec.ill = 1'b1;
            end
            OPC_OPIMM: begin
                w_dec.a  = w_rs1_val;
                w_dec.op = w_base_op;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_dec.b = w_shamt;
                    if (w_f3 == 3'b101 && w_f7 == 7'b0100000)
                        w_dec.op = ASR_OP;
                    else if (w_f7 != 7'b0000000)
                        w_dec.ill = 1'b1;
                end else begin
                    w_dec.b = w_imm_i;
                end
            end
            OPC_LUI: begin
                w_dec.b = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.a = pc_i;
                w_dec.b = w_imm_u;
            end
            OPC_LOAD: begin
                w_dec.a = w_rs1_val;
                w_dec.b = w_imm_i;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                    w_dec.ill = 1'b1;
            end
            OPC_STORE: begin
                w_dec.a  = w_rs1_val;
                w_dec.b  = w_imm_s;
                w_dec.rd = '0;
                if (w_f3 > 3'b010)
                    w_dec.ill = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.a  = w_rs1_val;
                w_dec.b  = w_rs2_val;
                w_dec.rd = '0;
                case (w_f3)
                    3'b000, 3'b001: w_dec.op = SUB_OP;
                    3'b100, 3'b101: w_dec.op = SLT_OP;
                    3'b110, 3'b111: w_dec.op = SLTU_OP;
                    default:        w_dec.ill = 1'b1;
                endcase
            end
            default: w_dec.ill = 1'b1;
        endcase
        if (w_dec.ill) begin
            w_dec.op = ADD_OP;
            w_dec.a  = '0;
            w_dec.b  = '0;
            w_dec.rd = '0;
        end
    end

    // next-state and load enables for the OUT/SKID pair; flush wins over all
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_out_in = 1'b1;
                    w_state_nxt   = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready_i) begin
                    if (w_accept)
                        w_load_out_in = 1'b1;
                    else
                        w_state_nxt = S_EMPTY;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_BOTH;
                end
            end
            S_BOTH: begin
                if (out_ready_i) begin
                    w_load_out_skid = 1'b1;
                    w_state_nxt     = S_FULL;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush_i) begin
            w_state_nxt     = S_EMPTY;
            w_load_out_in   = 1'b0;
            w_load_out_skid = 1'b0;
            w_load_skid     = 1'b0;
        end
    end

    // state register; in_ready is registered straight from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_BOTH);
        end
    end

    // OUT register: loaded from decode or promoted from SKID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_load_out_in) begin
            r_out <= w_dec;
        end else if (w_load_out_skid) begin
            r_out <= r_skid;
        end
    end

    // SKID register: catches the entry accepted while EX stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= w_dec;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed test-plan steps followed by random
// traffic, checked against a queue-based reference model of the stage.
module tb_alu_issue;

    localparam logic [5:0] ADD_OP  = 6'd0;
    localparam logic [5:0] SUB_OP  = 6'd1;
    localparam logic [5:0] SHL_OP  = 6'd2;
    localparam logic [5:0] LSR_OP  = 6'd3;
    localparam logic [5:0] ASR_OP  = 6'd4;
    localparam logic [5:0] OR_OP   = 6'd5;
    localparam logic [5:0] AND_OP  = 6'd6;
    localparam logic [5:0] XOR_OP  = 6'd7;
    localparam logic [5:0] SLT_OP  = 6'd9;
    localparam logic [5:0] SLTU_OP = 6'd10;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op_alu;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [4:0]  rd;
    logic        illegal;
    logic [31:0] res_alu;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    ent_t        q[$];
    logic        fwd_v  = 1'b0;
    logic [4:0]  fwd_rd = '0;

    alu_issue #(.XLEN(32), .OP_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .rs1_data_i  (rs1_data),
        .rs2_data_i  (rs2_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .op_alu_o    (op_alu),
        .opr_a_alu_o (opr_a),
        .opr_b_alu_o (opr_b),
        .rd_o        (rd),
        .illegal_o   (illegal),
        .res_alu_i   (res_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: RV32I semantics expressed as instruction classes
    function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                          input logic [31:0] r1, input logic [31:0] r2);
        ent_t        e;
        logic [5:0]  optab [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi;
        logic [31:0] imms;
        logic [31:0] immu;
        logic        ok;
        optab = '{ADD_OP, SHL_OP, SLT_OP, SLTU_OP, XOR_OP, LSR_OP, OR_OP, AND_OP};
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = 32'($signed(ins[31:20]));
        imms = 32'($signed({ins[31:25], ins[11:7]}));
        immu = {ins[31:12], 12'h000};
        ok   = 1'b1;
        e.op = ADD_OP; e.a = r1; e.b = r2; e.rd = ins[11:7]; e.ill = 1'b0;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) e.op = optab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.op = SUB_OP;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = ASR_OP;
                else ok = 1'b0;
            end
            7'h13: begin
                e.op = optab[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = 32'(ins[24:20]);
                    if (f3 == 3'd5 && f7 == 7'h20) e.op = ASR_OP;
                    else if (f7 != 7'h00) ok = 1'b0;
                end else begin
                    e.b = immi;
                end
            end
            7'h37: begin e.a = 32'd0;  e.b = immu; end
            7'h17: begin e.a = pcv;    e.b = immu; end
            7'h03: begin e.b = immi; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'h23: begin e.b = imms; e.rd = 5'd0; ok = (f3 <= 3'd2); end
            7'h63: begin
                e.rd = 5'd0;
                if (f3 inside {3'd0, 3'd1}) e.op = SUB_OP;
                else if (f3 inside {3'd4, 3'd5}) e.op = SLT_OP;
                else if (f3 inside {3'd6, 3'd7}) e.op = SLTU_OP;
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op = ADD_OP; e.a = 32'd0; e.b = 32'd0; e.rd = 5'd0; e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  bad [6];
        logic [2:0]  ld3 [5];
        bad = '{7'h7F, 7'h6F, 7'h67, 7'h73, 7'h0F, 7'h00};
        ld3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        w = $urandom();
        case ($urandom_range(0, 7))
            0: begin
                w[6:0] = 7'h33;
                if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: begin w[6:0] = 7'h03; w[14:12] = ld3[$urandom_range(0, 4)]; end
            5: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(0, 2)); end
            6: w[6:0] = 7'h63;
            default: w[6:0] = bad[$urandom_range(0, 5)];
        endcase
        return w;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".op"},  32'(op_alu),  32'(q[0].op));
            chk({tag, ".a"},   opr_a,        q[0].a);
            chk({tag, ".b"},   opr_b,        q[0].b);
            chk({tag, ".rd"},  32'(rd),      32'(q[0].rd));
            chk({tag, ".ill"}, 32'(illegal), 32'(q[0].ill));
        end
    endtask

    // One clock of stimulus: drive, advance the model across the edge, check
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res,
                       input logic ordy, input logic fl, input string tag);
        ent_t        e;
        logic        acc;
        logic        pop;
        logic [31:0] a1;
        logic [31:0] a2;
        logic        nv;
        logic [4:0]  nrd;
        in_valid = v; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
        res_alu = res; out_ready = ordy; flush = fl;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        a1 = r1;
        a2 = r2;
`ifdef ALU_BYPASS_EN
        if (fwd_v && ins[19:15] == fwd_rd) a1 = res;
        if (fwd_v && ins[24:20] == fwd_rd) a2 = res;
`endif
        e   = model_decode(ins, pcv, a1, a2);
        nv  = pop && (q[0].rd != 5'd0);
        nrd = pop ? q[0].rd : 5'd0;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        fwd_v  = nv;
        fwd_rd = nrd;
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0;
        rs1_data = '0; rs2_data = '0; out_ready = 1'b0; res_alu = '0;
        @(posedge clk); #1;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.a", opr_a, 32'd0);
        chk("reset.rd", 32'(rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        cyc(1'b1, {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0, "add");
        chk("tp_add.op", 32'(op_alu), 32'(ADD_OP));
        chk("tp_add.a", opr_a, 32'd5);
        chk("tp_add.b", opr_b, 32'd7);
        chk("tp_add.rd", 32'(rd), 32'd3);
        // ADDI x4,x1,-1
        cyc(1'b1, {12'hFFF, 5'd1, 3'd0, 5'd4, 7'h13}, 32'h0, 32'd1, 32'd9, 32'd0, 1'b1, 1'b0, "addi");
        chk("tp_addi.b", opr_b, 32'hFFFF_FFFF);
        // SRAI x4,x1,4
        cyc(1'b1, {7'h20, 5'd4, 5'd1, 3'd5, 5'd4, 7'h13}, 32'h0, 32'hF000_0000, 32'd0, 32'd0, 1'b1, 1'b0, "srai");
        chk("tp_srai.op", 32'(op_alu), 32'(ASR_OP));
        chk("tp_srai.b", opr_b, 32'd4);
        // AUIPC x7,0x12345
        cyc(1'b1, {20'h12345, 5'd7, 7'h17}, 32'h100, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, "auipc");
        chk("tp_auipc.a", opr_a, 32'h100);
        chk("tp_auipc.b", opr_b, 32'h1234_5000);
        // BLTU x1,x2
        cyc(1'b1, {7'h00, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63}, 32'h0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, "bltu");
        chk("tp_bltu.op", 32'(op_alu), 32'(SLTU_OP));
        chk("tp_bltu.rd", 32'(rd), 32'd0);
        // opcode 0x7F
        cyc(1'b1, 32'hFFFF_FFFF, 32'h40, 32'hAA, 32'hBB, 32'd0, 1'b1, 1'b0, "illegal");
        chk("tp_ill.ill", 32'(illegal), 32'd1);
        chk("tp_ill.a", opr_a, 32'd0);
        chk("tp_ill.b", opr_b, 32'd0);

        // forward test: ADD x5,x1,x2 handed off, then ADD x6,x5,x5 with stale operands
        cyc(1'b1, {7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33}, 32'h0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, "fwd0");
        cyc(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "fwd1");
        cyc(1'b1, {7'h00, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33}, 32'h0, 32'd0, 32'd0, 32'h42, 1'b1, 1'b0, "fwd2");
`ifdef ALU_BYPASS_EN
        chk("tp_fwd.a", opr_a, 32'h42);
        chk("tp_fwd.b", opr_b, 32'h42);
`else
        chk("tp_fwd.a", opr_a, 32'd0);
        chk("tp_fwd.b", opr_b, 32'd0);
`endif
        cyc(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "drain");

        // stall: three back-to-back entries with rd 1,2,3
        cyc(1'b1, {12'd1, 5'd0, 3'd0, 5'd1, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "bb1");
        cyc(1'b1, {12'd2, 5'd0, 3'd0, 5'd2, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "bb2");
        chk("tp_bb.in_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, {12'd3, 5'd0, 3'd0, 5'd3, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "bb3");
        chk("tp_bb.hold_rd", 32'(rd), 32'd1);
        cyc(1'b1, {12'd3, 5'd0, 3'd0, 5'd3, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "bb4");
        chk("tp_bb.second_rd", 32'(rd), 32'd2);
        chk("tp_bb.second_v", 32'(out_valid), 32'd1);
        cyc(1'b1, {12'd3, 5'd0, 3'd0, 5'd3, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "bb5");
        chk("tp_bb.third_rd", 32'(rd), 32'd3);
        chk("tp_bb.third_v", 32'(out_valid), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "bb6");

        // flush while in BOTH with a new entry offered
        cyc(1'b1, {12'd4, 5'd0, 3'd0, 5'd4, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "fl1");
        cyc(1'b1, {12'd5, 5'd0, 3'd0, 5'd5, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "fl2");
        cyc(1'b1, {12'd6, 5'd0, 3'd0, 5'd6, 7'h13}, 32'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, "fl3");
        chk("tp_flush.valid", 32'(out_valid), 32'd0);
        chk("tp_flush.in_ready", 32'(in_ready), 32'd1);

        // asynchronous reset mid-stream, away from any clock edge
        cyc(1'b1, {7'h00, 5'd2, 5'd1, 3'd4, 5'd9, 7'h33}, 32'h0, 32'd6, 32'd3, 32'd0, 1'b0, 1'b0, "ar1");
        cyc(1'b1, {7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'h33}, 32'h0, 32'd6, 32'd3, 32'd0, 1'b0, 1'b0, "ar2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        chk("async_rst.op", 32'(op_alu), 32'd0);
        chk("async_rst.a", opr_a, 32'd0);
        chk("async_rst.b", opr_b, 32'd0);
        chk("async_rst.rd", 32'(rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        fwd_v = 1'b0;

        // random traffic against the model
        for (int unsigned i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 9) < 7, rand_instr(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-side issue stage driving the pipeline ALU's request interface: op code, operand A and operand B.
- Decodes an RV32I instruction word plus register-file read data into `op_alu_o`, `opr_a_alu_o` and `opr_b_alu_o`.
- Registers the result as the ID/EX pipeline register, behind a valid/ready handshake with a one-entry skid buffer.
- Sits between decode/register-read and the combinational ALU; absorbs EX-stage stalls and honours flushes.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- OP_W, 6, ALU op-code width. Encodings come from the shared ALU defines header: ADD_OP, SUB_OP, SHL_OP, LSR_OP, ASR_OP, OR_OP, AND_OP, XOR_OP, NOR_OP, SLT_OP, SLTU_OP.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous flush; drops all held and incoming entries
- in_valid_i  input  1  upstream entry valid
- in_ready_o  output  1  stage can accept an entry
- instr_i  input  32  instruction word
- pc_i  input  32  instruction PC
- rs1_data_i  input  32  register-file read of rs1
- rs2_data_i  input  32  register-file read of rs2
- out_valid_o  output  1  ALU request valid
- out_ready_i  input  1  EX stage accepts request
- op_alu_o  output  6  ALU op code
- opr_a_alu_o  output  32  ALU operand A
- opr_b_alu_o  output  32  ALU operand B
- rd_o  output  5  destination register; 0 when none
- illegal_o  output  1  entry held an unsupported opcode/funct
- res_alu_i  input  32  ALU result feedback; used only with ALU_BYPASS_EN

Behaviour:
- Reset (rst_n low, asynchronous): all outputs zero; in_ready_o=1; state EMPTY.

Decode, combinational on the input side:
- OP (0110011): funct3/funct7 select ADD/SUB/SHL/LSR/ASR/OR/AND/XOR/SLT/SLTU. A=rs1, B=rs2.
- OP-IMM (0010011): same ops, B=sign-extended imm[11:0]. For shifts, B={27'b0,shamt}. SUB is not legal here. Shift with funct7 not in {0000000, 0100000 for SRAI} → illegal.
- LUI: ADD, A=0, B={imm[31:12],12'b0}.
- AUIPC: ADD, A=pc_i, B={imm[31:12],12'b0}.
- LOAD/STORE: ADD, A=rs1, B=sign-extended I/S immediate; rd_o=0 for STORE.
- BRANCH: BEQ/BNE→SUB; BLT/BGE→SLT; BLTU/BGEU→SLTU. A=rs1, B=rs2; rd_o=0.
- Any other opcode/funct combination: illegal_o=1, op=ADD_OP, A=B=0, rd_o=0.

State machine (registered entry = OUT, skid entry = SKID):
- EMPTY: in_valid_i → load OUT, go FULL. in_ready_o=1.
- FULL, out_ready_i=1: in_valid_i reloads OUT (stay FULL); otherwise go EMPTY.
- FULL, out_ready_i=0, in_valid_i=1: capture into SKID, go BOTH.
- BOTH: in_ready_o=0. On out_ready_i, SKID moves to OUT, go FULL.
- in_ready_o is a registered output: 1 in EMPTY/FULL, 0 in BOTH.
- out_valid_o=1 in FULL/BOTH.
- Latency: 1 cycle from accepted input to out_valid_o.
- Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- flush_i: next state EMPTY and out_valid_o=0, regardless of concurrent in_valid_i or out_ready_i. Data registers need not clear.
- Ordering is strict FIFO. No entry is lost or duplicated.

Optional Feature:
- ALU_BYPASS_EN defined: track rd of the entry last handed to EX on the previous cycle (a handshake occurred).
- If the accepted instruction's rs1 (or rs2, when used) equals that rd and rd≠0, substitute res_alu_i for the register data.
- The bypass applies only on the cycle immediately after the handshake and only when the entry is loaded directly from input.
- A SKID entry resolves its bypass at capture time.
- Undefined: res_alu_i is ignored, no rd tracking logic exists, and operands come only from rs1_data_i/rs2_data_i.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready_i=1 → next cycle out_valid_o=1, op=ADD_OP, A=5, B=7, rd_o=3.
- ADDI with imm=0xFFF, rs1=1 → B=0xFFFFFFFF. SRAI shamt=4 → op=ASR_OP, B=4. AUIPC imm=0x12345 at pc=0x100 → A=0x100, B=0x12345000.
- BLTU → op=SLTU_OP, rd_o=0. Opcode 0x7F → illegal_o=1, A=B=0.
- Hold out_ready_i=0 and send 3 back-to-back entries → entry 1 in OUT, entry 2 in SKID, in_ready_o=0 and entry 3 held upstream. Release → outputs 1,2,3 in order, no gaps after the first.
- flush_i in BOTH with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1. Deassert rst_n mid-stream → outputs zero immediately, without a clock edge.
- ALU_BYPASS_EN: ADD x5,… then ADD x6,x5,x5 with res_alu_i=0x42 and stale rs data=0 → A=B=0x42. Without the macro → A=B=0.
